// File: rtl/gps_sim_pkg.sv
// Shared types and default sizing for the GPS simulation stimulus blocks.
// DIV_10K assumes the 100 MHz core clock the old 10 kHz prescaler was built for.
package gps_sim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } player_state_t;

    localparam int DEF_WIDTH  = 1;
    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DIV_W  = 16;
    localparam int CLK_HZ     = 100_000_000;
    localparam int DIV_10K    = CLK_HZ / 10_000 - 1;

endpackage

// File: rtl/sample_ram_sdp.sv
// Simple-dual-port sample RAM: one write port, one synchronous read-first read port.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; both ports accept every cycle.
module sample_ram_sdp #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Array deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; NBA ordering gives read-first on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_player.sv
// Replays the sample RAM at a decimated rate, one-shot or looping, with start/stop control.
// Latency: first strobe two cycles after start; then one strobe every rate_div+1 cycles.
// Backpressure: none; the consumer must accept every sample_valid strobe.
module sample_player
    import gps_sim_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  rate_div,
    output logic [WIDTH-1:0]  sample_out,
    output logic              sample_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done
);

    player_state_t     state, state_nxt;
    logic              loop_q;
    logic [ADDR_W-1:0] end_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic              issue;
    logic              last_rd;
    logic              final_rd;
    logic              div_wrap;

    assign issue    = (state == RUN) && (div_cnt == '0) && !stop;
    assign last_rd  = (rd_addr == end_q);
    assign final_rd = issue && last_rd && !loop_q;
    assign div_wrap = (div_cnt == div_q);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_nxt = RUN;
            end
            RUN: begin
                if (stop)          state_nxt = IDLE;
                else if (start)    state_nxt = RUN;
                else if (final_rd) state_nxt = DONE;
            end
            DONE: begin
                if (stop)       state_nxt = IDLE;
                else if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rd_addr is advanced on the edge into the issue cycle, so it always shows the
    // address being read now or, between reads, the one read last.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sample_valid <= 1'b0;
            loop_q       <= 1'b0;
            end_q        <= '0;
            div_q        <= '0;
            div_cnt      <= '0;
            rd_addr      <= '0;
        end else begin
            sample_valid <= issue;
            if (stop) begin
                div_cnt <= div_cnt;
            end else if (start) begin
                loop_q  <= loop_mode;
                end_q   <= end_addr;
                div_q   <= rate_div;
                div_cnt <= '0;
                rd_addr <= '0;
            end else if ((state == RUN) && !final_rd) begin
                div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                if (div_wrap) begin
                    rd_addr <= last_rd ? '0 : rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    sample_ram_sdp #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RST_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (sample_out)
    );

endmodule

// File: doc/sample_player.md
# sample_player

Parametrised playback source for the GPS receiver chain: an internal simple-dual-port sample memory loaded through a write port and replayed at a programmable decimated rate, in one-shot or loop mode. Replaces the fixed 1-bit, free-running address-counter stimulus in front of `top_costas`. Generalises sample width and depth, and adds start/stop control, end-address wrap and a done indication.

## Interface
- `WIDTH`, 1: sample width in bits (1 = sign-only IF, 2–4 = multi-bit ADC).
- `ADDR_W`, 22: address width; memory depth is 2**ADDR_W.
- `DIV_W`, 16: width of the rate divider.

- `CLK` in 1: single clock; reset is asynchronous and active-low.
- `RST_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: memory write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in WIDTH: write data.
- `start` in 1: start or restart playback pulse.
- `stop` in 1: abort playback pulse.
- `loop_mode` in 1: 1 = wrap to 0 after `end_addr`; 0 = one-shot.
- `end_addr` in ADDR_W: last address played (inclusive).
- `rate_div` in DIV_W: one sample every `rate_div`+1 cycles.
- `sample_out` out WIDTH: current sample; held between strobes.
- `sample_valid` out 1: one-cycle strobe when `sample_out` updates.
- `rd_addr` out ADDR_W: address of the most recently issued read.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `start` -> RUN.
  - RUN: `stop` -> IDLE; last one-shot sample emitted -> DONE.
  - DONE: `start` -> RUN; `stop` -> IDLE.
- On `start`, latch `loop_mode`, `end_addr` and `rate_div`. Later changes to these inputs have no effect until the next `start`.
- In RUN, the divider counter counts 0..`rate_div`. A read is issued when the counter is 0. The first read is issued in the first RUN cycle at address 0.
- Address update after a read:
  - Read address < `end_addr`: address increments.
  - Read address == `end_addr`, loop: address becomes 0.
  - Read address == `end_addr`, one-shot: no further reads.
- `end_addr` = 0 plays `mem[0]` only (or repeats it in loop mode).
- `stop` has priority over `start` in the same cycle. After the `stop` cycle no `sample_valid` is produced, including for a read already in flight.
- `start` while in RUN restarts from address 0 with freshly latched settings.
- Writes are accepted in any state. A read and a write to the same address in the same cycle return the old data (read-first).
- Memory contents are not reset.
- Reset values: state IDLE; `sample_out` 0; `sample_valid`, `busy`, `done` 0; `rd_addr` 0; divider counter 0.
- Reset asserted mid-playback returns all outputs to reset values immediately. Memory contents are retained.

## Timing
- Memory read latency is 1 cycle. `sample_valid` and `sample_out` are registered.
- With `start` at cycle t in IDLE:
  - `busy` = 1 at t+1; read of address 0 at t+1.
  - `sample_valid` with `mem[0]` at t+2.
  - Subsequent strobes every `rate_div`+1 cycles.
- One-shot: `done` rises and `busy` falls in the same cycle as the final `sample_valid` (the sample for `end_addr`).
- Loop mode never asserts `done`.
- `rate_div` = 0 gives a strobe every cycle with no gaps, including across the wrap.
- `rd_addr` updates in the read-issue cycle.

## Structure
- Shared package `gps_sim_pkg`:
  - `player_state_t` enum {IDLE, RUN, DONE}.
  - Default parameter constants: sample width, address width, divider width, and `DIV_10K`, the divider value equivalent to the existing 10 kHz prescaler.
- One sub-module: `sample_ram_sdp`, a parametrised simple-dual-port RAM with one write port, one synchronous read port, read-first behaviour and no reset on the array.
- FSM, divider and address counter stay in `sample_player`.

## Test plan
- Load `mem[0..7]` = 1,0,1,1,0,0,1,0 (WIDTH=1); `end_addr`=7, `rate_div`=0, one-shot; `start` -> 8 consecutive strobes in that order starting t+2; `done`=1 and `busy`=0 on the 8th strobe.
- WIDTH=3, `rate_div`=4, `end_addr`=2, loop -> strobes every 5 cycles, sequence `mem[0],mem[1],mem[2],mem[0]…`; `done` never rises.
- `stop` asserted in the cycle a read is issued -> no further `sample_valid`; `busy`=0 next cycle; `rd_addr` holds.
- `start` and `stop` in the same cycle from IDLE -> stays IDLE; `start` in DONE -> replays from `mem[0]` with a strobe at t+2.
- Write `mem[3]`=1 in the same cycle as the read of address 3 (old value 0) -> strobe shows 0; the next loop pass shows 1.
- `RST_n` pulsed low mid-RUN at address 5 -> all outputs 0 asynchronously; after `start`, playback begins at `mem[0]` and memory contents are intact.
